// File: rtl/data_cache_assoc.sv
// N-way set-associative write-back/write-allocate data cache, one word per line.
// Optional hit/miss counters are enabled with `define DATA_CACHE_STATS_EN.
module data_cache_assoc #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SETS        = 16,
    parameter int WAYS        = 2,
    parameter int OFFSET_BITS = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpuReq,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  cpuReady,
    output logic                  busy,
    output logic                  extReq,
    output logic                  extWe,
    output logic [ADDR_WIDTH-1:0] extAddr,
    output logic [DATA_WIDTH-1:0] extWData,
    input  logic                  extAck,
    input  logic [DATA_WIDTH-1:0] extRData
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0]           hitCount,
    output logic [31:0]           missCount
`endif
);

    localparam int INDEX_BITS = $clog2(SETS);
    localparam int LINE_BITS  = ADDR_WIDTH - OFFSET_BITS;
    localparam int TAG_BITS   = LINE_BITS - INDEX_BITS;
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_RESPOND
    } state_t;

    state_t state_q, state_d;

    logic                  req_write_q, req_write_d;
    logic [LINE_BITS-1:0]  req_line_q,  req_line_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [WAY_W-1:0]      victim_q,    victim_d;

    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  ext_req_q,   ext_req_d;
    logic                  ext_we_q,    ext_we_d;
    logic [ADDR_WIDTH-1:0] ext_addr_q,  ext_addr_d;
    logic [DATA_WIDTH-1:0] ext_wdata_q, ext_wdata_d;

    logic [TAG_BITS-1:0]   tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WAY_W-1:0]      ptr_q   [SETS];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      vic_way;
    logic                  found_inv;
    logic                  vic_dirty;
    logic                  ack;

    logic                  arr_we;
    logic [WAY_W-1:0]      arr_way;
    logic [TAG_BITS-1:0]   arr_tag;
    logic [DATA_WIDTH-1:0] arr_data;
    logic                  arr_dirty;
    logic                  adv_ptr;
    logic                  clr_dirty;
    logic                  cnt_hit;
    logic                  cnt_miss;

    assign req_index = req_line_q[INDEX_BITS-1:0];
    assign req_tag   = req_line_q[LINE_BITS-1:INDEX_BITS];
    // An acknowledge only counts while a request is actually outstanding.
    assign ack       = extAck & ext_req_q;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vic_way   = ptr_q[req_index];
        found_inv = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_index][w] && !found_inv) begin
                found_inv = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        vic_dirty = valid_q[req_index][vic_way] & dirty_q[req_index][vic_way];
    end

    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_line_d  = req_line_q;
        req_wdata_d = req_wdata_q;
        victim_d    = victim_q;
        read_data_d = read_data_q;
        cpu_ready_d = 1'b0;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        arr_we      = 1'b0;
        arr_way     = victim_q;
        arr_tag     = req_tag;
        arr_data    = req_wdata_q;
        arr_dirty   = 1'b0;
        adv_ptr     = 1'b0;
        clr_dirty   = 1'b0;
        cnt_hit     = 1'b0;
        cnt_miss    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cpuReq && (memRead || memWrite)) begin
                    req_write_d = memWrite;
                    req_line_d  = address[ADDR_WIDTH-1:OFFSET_BITS];
                    req_wdata_d = writeData;
                    state_d     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    cnt_hit     = 1'b1;
                    cpu_ready_d = 1'b1;
                    state_d     = S_IDLE;
                    if (req_write_q) begin
                        arr_we      = 1'b1;
                        arr_way     = hit_way;
                        arr_tag     = req_tag;
                        arr_data    = req_wdata_q;
                        arr_dirty   = 1'b1;
                        read_data_d = req_wdata_q;
                    end else begin
                        read_data_d = data_q[req_index][hit_way];
                    end
                end else begin
                    cnt_miss = 1'b1;
                    victim_d = vic_way;
                    if (vic_dirty) begin
                        ext_req_d   = 1'b1;
                        ext_we_d    = 1'b1;
                        ext_addr_d  = {tag_q[req_index][vic_way], req_index, {OFFSET_BITS{1'b0}}};
                        ext_wdata_d = data_q[req_index][vic_way];
                        state_d     = S_WRITEBACK;
                    end else if (req_write_q) begin
                        arr_we      = 1'b1;
                        arr_way     = vic_way;
                        arr_dirty   = 1'b1;
                        adv_ptr     = 1'b1;
                        read_data_d = req_wdata_q;
                        cpu_ready_d = 1'b1;
                        state_d     = S_RESPOND;
                    end else begin
                        ext_req_d  = 1'b1;
                        ext_we_d   = 1'b0;
                        ext_addr_d = {req_line_q, {OFFSET_BITS{1'b0}}};
                        state_d    = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                if (ack) begin
                    ext_req_d = 1'b0;
                    clr_dirty = 1'b1;
                    if (req_write_q) begin
                        arr_we      = 1'b1;
                        arr_way     = victim_q;
                        arr_dirty   = 1'b1;
                        adv_ptr     = 1'b1;
                        read_data_d = req_wdata_q;
                        cpu_ready_d = 1'b1;
                        state_d     = S_RESPOND;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end
            end
            S_ALLOCATE: begin
                // After a writeback the request line drops for one cycle before the fill is issued.
                if (!ext_req_q) begin
                    ext_req_d  = 1'b1;
                    ext_we_d   = 1'b0;
                    ext_addr_d = {req_line_q, {OFFSET_BITS{1'b0}}};
                end else if (ack) begin
                    ext_req_d   = 1'b0;
                    arr_we      = 1'b1;
                    arr_way     = victim_q;
                    arr_data    = extRData;
                    arr_dirty   = 1'b0;
                    adv_ptr     = 1'b1;
                    read_data_d = extRData;
                    cpu_ready_d = 1'b1;
                    state_d     = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_write_q <= 1'b0;
            req_line_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            read_data_q <= '0;
            cpu_ready_q <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_line_q  <= req_line_d;
            req_wdata_q <= req_wdata_d;
            victim_q    <= victim_d;
            read_data_q <= read_data_d;
            cpu_ready_q <= cpu_ready_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            if (clr_dirty) begin
                dirty_q[req_index][victim_q] <= 1'b0;
            end
            if (arr_we) begin
                valid_q[req_index][arr_way] <= 1'b1;
                dirty_q[req_index][arr_way] <= arr_dirty;
            end
            if (adv_ptr) begin
                ptr_q[req_index] <= (ptr_q[req_index] == LAST_WAY) ? '0
                                    : ptr_q[req_index] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (arr_we) begin
            tag_q[req_index][arr_way]  <= arr_tag;
            data_q[req_index][arr_way] <= arr_data;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cnt_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (cnt_miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`endif

    assign readData = read_data_q;
    assign cpuReady = cpu_ready_q;
    assign busy     = (state_q != S_IDLE);
    assign extReq   = ext_req_q;
    assign extWe    = ext_we_q;
    assign extAddr  = ext_addr_q;
    assign extWData = ext_wdata_q;

endmodule

// File: tb/tb_data_cache_assoc.sv
// Directed self-checking bench for data_cache_assoc with a responsive backing memory.
module tb_data_cache_assoc;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpuReq, memRead, memWrite;
    logic [31:0] address, writeData, readData;
    logic        cpuReady, busy, extReq, extWe, extAck;
    logic [31:0] extAddr, extWData, extRData;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hitCount, missCount;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] r_data, r_wb_addr, r_wb_data, r_fill_addr;
    int          r_cycles, r_nwb, r_nfill;

    always #5 clock = ~clock;

    data_cache_assoc #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SETS       (16),
        .WAYS       (2),
        .OFFSET_BITS(3)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cpuReq   (cpuReq),
        .memRead  (memRead),
        .memWrite (memWrite),
        .address  (address),
        .writeData(writeData),
        .readData (readData),
        .cpuReady (cpuReady),
        .busy     (busy),
        .extReq   (extReq),
        .extWe    (extWe),
        .extAddr  (extAddr),
        .extWData (extWData),
        .extAck   (extAck),
        .extRData (extRData)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hitCount (hitCount),
        .missCount(missCount)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issues one core request and services external traffic until cpuReady.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] fill);
        bit done;
        done        = 1'b0;
        r_nwb       = 0;
        r_nfill     = 0;
        r_wb_addr   = '0;
        r_wb_data   = '0;
        r_fill_addr = '0;
        r_data      = '0;
        @(negedge clock);
        cpuReq    = 1'b1;
        memRead   = rd;
        memWrite  = wr;
        address   = addr;
        writeData = wd;
        @(posedge clock);
        r_cycles = 1;
        #1;
        cpuReq   = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (cpuReady) begin
                r_data = readData;
                done   = 1'b1;
            end else begin
                if (extReq && !extAck) begin
                    if (extWe) begin
                        r_nwb++;
                        r_wb_addr = extAddr;
                        r_wb_data = extWData;
                    end else begin
                        r_nfill++;
                        r_fill_addr = extAddr;
                    end
                    extAck   = 1'b1;
                    extRData = fill;
                end else begin
                    extAck = 1'b0;
                end
                @(posedge clock);
                r_cycles++;
            end
        end
        extAck = 1'b0;
        if (!done) check_eq("txn_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        cpuReq    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        extAck    = 1'b0;
        extRData  = '0;
        repeat (2) @(negedge clock);
        check_eq("rst_readData", readData, 32'h0);
        check_eq("rst_cpuReady", {31'b0, cpuReady}, 32'h0);
        check_eq("rst_busy", {31'b0, busy}, 32'h0);
        check_eq("rst_extReq", {31'b0, extReq}, 32'h0);
        reset_n = 1'b1;

        // Cold read miss, then hit
        do_txn(1'b1, 1'b0, 32'h0000_0808, 32'h0, 32'h0101_0101);
        check_eq("s1_fill_cnt", r_nfill, 1);
        check_eq("s1_fill_addr", r_fill_addr, 32'h0000_0808);
        check_eq("s1_wb_cnt", r_nwb, 0);
        check_eq("s1_rdata", r_data, 32'h0101_0101);
        do_txn(1'b1, 1'b0, 32'h0000_0808, 32'h0, 32'hDEAD_0000);
        check_eq("s1_hit_ext", r_nfill + r_nwb, 0);
        check_eq("s1_hit_rdata", r_data, 32'h0101_0101);
        check_eq("s1_hit_latency", r_cycles, 2);

        // Clean write miss allocates without external traffic
        do_txn(1'b0, 1'b1, 32'h0000_0810, 32'hFADE_CAFE, 32'hDEAD_0001);
        check_eq("s2_wr_ext", r_nfill + r_nwb, 0);
        check_eq("s2_wr_rdata", r_data, 32'hFADE_CAFE);
        do_txn(1'b1, 1'b0, 32'h0000_0810, 32'h0, 32'hDEAD_0002);
        check_eq("s2_rd_ext", r_nfill + r_nwb, 0);
        check_eq("s2_rd_rdata", r_data, 32'hFADE_CAFE);
        check_eq("s2_rd_latency", r_cycles, 2);

        // Index-1 conflicts: round-robin victims and dirty writebacks
        do_txn(1'b0, 1'b1, 32'h0000_0008, 32'hAAAA_0001, 32'hDEAD_0003);
        check_eq("s3_w1_ext", r_nfill + r_nwb, 0);
        do_txn(1'b0, 1'b1, 32'h0000_0088, 32'hAAAA_0002, 32'hDEAD_0004);
        check_eq("s3_w2_ext", r_nfill + r_nwb, 0);
        do_txn(1'b1, 1'b0, 32'h0000_0108, 32'h0, 32'h3333_0003);
        check_eq("s3_r1_wb_cnt", r_nwb, 1);
        check_eq("s3_r1_wb_addr", r_wb_addr, 32'h0000_0008);
        check_eq("s3_r1_wb_data", r_wb_data, 32'hAAAA_0001);
        check_eq("s3_r1_fill_addr", r_fill_addr, 32'h0000_0108);
        check_eq("s3_r1_rdata", r_data, 32'h3333_0003);
        do_txn(1'b1, 1'b0, 32'h0000_0188, 32'h0, 32'h4444_0004);
        check_eq("s3_r2_wb_cnt", r_nwb, 1);
        check_eq("s3_r2_wb_addr", r_wb_addr, 32'h0000_0088);
        check_eq("s3_r2_wb_data", r_wb_data, 32'hAAAA_0002);
        check_eq("s3_r2_fill_addr", r_fill_addr, 32'h0000_0188);
        check_eq("s3_r2_rdata", r_data, 32'h4444_0004);

        // Write hit dirties a line; a later write miss writes it back with no fill
        do_txn(1'b0, 1'b1, 32'h0000_0108, 32'h6666_0006, 32'hDEAD_0005);
        check_eq("s3_whit_ext", r_nfill + r_nwb, 0);
        check_eq("s3_whit_latency", r_cycles, 2);
        do_txn(1'b0, 1'b1, 32'h0000_0208, 32'h7777_0007, 32'hDEAD_0006);
        check_eq("s3_wmiss_wb_cnt", r_nwb, 1);
        check_eq("s3_wmiss_fill_cnt", r_nfill, 0);
        check_eq("s3_wmiss_wb_addr", r_wb_addr, 32'h0000_0108);
        check_eq("s3_wmiss_wb_data", r_wb_data, 32'h6666_0006);
        check_eq("s3_wmiss_rdata", r_data, 32'h7777_0007);
        do_txn(1'b1, 1'b0, 32'h0000_0208, 32'h0, 32'hDEAD_0007);
        check_eq("s3_rb_ext", r_nfill + r_nwb, 0);
        check_eq("s3_rb_rdata", r_data, 32'h7777_0007);

        // Read and write together behave as a write
        do_txn(1'b1, 1'b1, 32'h0000_0010, 32'hC0DE_BABE, 32'hDEAD_0008);
        check_eq("s4_ext", r_nfill + r_nwb, 0);
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_0009);
        check_eq("s4_rdata", r_data, 32'hC0DE_BABE);
        check_eq("s4_rd_ext", r_nfill + r_nwb, 0);

        // Request with neither read nor write is ignored
        @(negedge clock);
        cpuReq  = 1'b1;
        address = 32'h0000_0808;
        @(negedge clock);
        check_eq("noop_busy", {31'b0, busy}, 32'h0);
        cpuReq = 1'b0;

        // Reset mid-allocate, then a stray acknowledge
        @(negedge clock);
        cpuReq  = 1'b1;
        memRead = 1'b1;
        address = 32'h0000_0900;
        @(posedge clock);
        #1;
        cpuReq  = 1'b0;
        memRead = 1'b0;
        for (int i = 0; i < 10 && !extReq; i++) @(negedge clock);
        check_eq("s5_extReq", {31'b0, extReq}, 32'h1);
        check_eq("s5_extWe", {31'b0, extWe}, 32'h0);
        check_eq("s5_extAddr", extAddr, 32'h0000_0900);
        check_eq("s5_busy", {31'b0, busy}, 32'h1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("s5_rst_readData", readData, 32'h0);
        check_eq("s5_rst_cpuReady", {31'b0, cpuReady}, 32'h0);
        check_eq("s5_rst_busy", {31'b0, busy}, 32'h0);
        check_eq("s5_rst_extReq", {31'b0, extReq}, 32'h0);
        check_eq("s5_rst_extWe", {31'b0, extWe}, 32'h0);
        check_eq("s5_rst_extAddr", extAddr, 32'h0);
        check_eq("s5_rst_extWData", extWData, 32'h0);
        @(negedge clock);
        reset_n  = 1'b1;
        extAck   = 1'b1;
        extRData = 32'hBAD0_BAD0;
        @(negedge clock);
        extAck = 1'b0;
        check_eq("s5_late_ack_extReq", {31'b0, extReq}, 32'h0);
        check_eq("s5_late_ack_busy", {31'b0, busy}, 32'h0);
        check_eq("s5_late_ack_ready", {31'b0, cpuReady}, 32'h0);
        do_txn(1'b1, 1'b0, 32'h0000_0808, 32'h0, 32'h5A5A_5A5A);
        check_eq("s5_reread_fill_cnt", r_nfill, 1);
        check_eq("s5_reread_fill_addr", r_fill_addr, 32'h0000_0808);
        check_eq("s5_reread_rdata", r_data, 32'h5A5A_5A5A);
        do_txn(1'b1, 1'b0, 32'h0000_0808, 32'h0, 32'hDEAD_000A);
        check_eq("s5_hit_rdata", r_data, 32'h5A5A_5A5A);
        check_eq("s5_hit_ext", r_nfill + r_nwb, 0);
`ifdef DATA_CACHE_STATS_EN
        @(negedge clock);
        check_eq("s6_hitCount", hitCount, 32'd1);
        check_eq("s6_missCount", missCount, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
